det_event_counter: RTL and testbench
====================================

DET_EVENT_COUNTER -- requirements
Module: det_event_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of the detection counter.
REQ-002 The block SHALL have parameter THRESH, default 4: count at which irq asserts; legal range 1..2^WIDTH-1.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port w  input  1  detect flag from the upstream sequence-detector FSM.
REQ-006 The block SHALL have port clr  input  1  synchronous clear request.
REQ-007 The block SHALL have port ack  input  1  interrupt acknowledge.
REQ-008 The block SHALL have port count  output  WIDTH  current detection count, registered.
REQ-009 The block SHALL have port irq  output  1  threshold-reached interrupt, registered.
REQ-010 The block SHALL have port ovf  output  1  sticky counter-overflow flag, registered.

Function
REQ-011 The block SHALL register w into w_q every cycle and define event = w AND NOT w_q, so w held high for any number of cycles counts as exactly one detection.
REQ-012 The block SHALL implement a 3-state FSM: IDLE (count==0, irq=0), ARMED (0<count<THRESH, irq=0), ALERT (irq=1).
REQ-013 On an event, count SHALL increment by 1 at the next rising edge, giving 1-cycle latency from a sampled event to the updated count.
REQ-014 IDLE SHALL go to ARMED on an event, or directly to ALERT when THRESH==1.
REQ-015 ARMED SHALL go to ALERT on the edge where the incremented count equals THRESH, with irq rising on that same edge.
REQ-016 In ALERT, irq SHALL stay high until ack, and count SHALL keep incrementing on further events.
REQ-017 ack in ALERT without an event SHALL clear count to 0 and return the FSM to IDLE.
REQ-018 ack in ALERT with a simultaneous event SHALL set count to 1 and the FSM to ARMED, or to ALERT when THRESH==1.
REQ-019 ack outside ALERT SHALL be ignored.
REQ-020 clr SHALL have priority over event and ack: count goes to 0, ovf to 0, and the FSM to IDLE on the next edge, discarding any same-cycle event.
REQ-021 An event with count == 2^WIDTH-1 SHALL set ovf to 1; ovf SHALL remain set until clr or reset, and ack SHALL NOT clear it.
REQ-022 A wrap of count while in ALERT SHALL NOT leave ALERT; irq SHALL remain asserted until ack.
REQ-023 w_q SHALL update every cycle regardless of clr or ack.

Reset
REQ-024 On assertion of rst (low), the block SHALL asynchronously clear count, irq, ovf and w_q to 0 and set the FSM to IDLE.
REQ-025 Reset asserted mid-count or during ALERT SHALL abandon all state without any further irq pulse.
REQ-026 After rst deasserts, the block SHALL resume operation on the first rising edge of clk.
REQ-027 A w already high at reset release SHALL count as an event, since w_q resets to 0.

Configuration
REQ-028 The block SHALL support macro DET_SAT_EN.
REQ-029 With DET_SAT_EN defined, an event at count == 2^WIDTH-1 SHALL hold count at 2^WIDTH-1 (saturate) and set ovf.
REQ-030 With DET_SAT_EN undefined, an event at count == 2^WIDTH-1 SHALL wrap count to 0 and set ovf.
REQ-031 All other behaviour SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL cover: reset, then 1-cycle w pulses on cycles 3, 6, 9 -> count 1, 2, 3 one cycle after each pulse; irq=0; FSM in ARMED.
REQ-033 The bench SHALL cover: w held high for 5 cycles -> count increments once only, from 0 to 1.
REQ-034 The bench SHALL cover: THRESH=4 with 4 pulses -> irq=1 on the edge count becomes 4; a fifth pulse gives count 5 with irq still 1; ack gives count 0, irq 0, FSM in IDLE.
REQ-035 The bench SHALL cover: in ALERT, ack and an event in the same cycle -> count 1, irq 0, FSM in ARMED.
REQ-036 The bench SHALL cover: WIDTH=4, 16 pulses -> count 0 and ovf 1 without DET_SAT_EN; count 15 and ovf 1 with DET_SAT_EN; a following clr gives count 0 and ovf 0.
REQ-037 The bench SHALL cover: rst driven low asynchronously mid-cycle while in ALERT with count 6 -> count, irq and ovf read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/det_event_counter.sv
// Edge-qualified detection counter with threshold interrupt and sticky overflow.
// Define DET_SAT_EN to saturate the counter at its maximum instead of wrapping.
module det_event_counter #(
   parameter int WIDTH  = 8,
   parameter int THRESH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w,
   input  logic             clr,
   input  logic             ack,
   output logic [WIDTH-1:0] count,
   output logic             irq,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [WIDTH-1:0] THRESH_V   = THRESH[WIDTH-1:0];
   localparam bit               THRESH_ONE = (THRESH == 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      ALERT = 2'd2
   } state_t;

   state_t           state;
   logic             w_q;
   logic             evt;
   logic             at_max;
   logic [WIDTH-1:0] cnt_inc;
   logic             hit;

   function automatic logic [WIDTH-1:0] inc_cnt(input logic [WIDTH-1:0] c);
`ifdef DET_SAT_EN
      return (c == CNT_MAX) ? CNT_MAX : c + WIDTH'(1);
`else
      return c + WIDTH'(1);
`endif
   endfunction

   // Rising edge of the detector flag: a held-high w counts only once.
   assign evt     = w & ~w_q;
   assign at_max  = (count == CNT_MAX);
   assign cnt_inc = inc_cnt(count);
   assign hit     = (cnt_inc == THRESH_V);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         irq   <= 1'b0;
         ovf   <= 1'b0;
         w_q   <= 1'b0;
      end else begin
         w_q <= w;
         if (clr) begin
            state <= IDLE;
            count <= '0;
            irq   <= 1'b0;
            ovf   <= 1'b0;
         end else begin
            case (state)
               IDLE, ARMED: begin
                  if (evt) begin
                     count <= cnt_inc;
                     if (hit) begin
                        state <= ALERT;
                        irq   <= 1'b1;
                     end else begin
                        state <= ARMED;
                     end
                  end
               end
               ALERT: begin
                  // An acknowledged event restarts counting from one.
                  if (ack) begin
                     if (evt) begin
                        count <= WIDTH'(1);
                        state <= THRESH_ONE ? ALERT : ARMED;
                        irq   <= THRESH_ONE;
                     end else begin
                        count <= '0;
                        state <= IDLE;
                        irq   <= 1'b0;
                     end
                  end else if (evt) begin
                     count <= cnt_inc;
                  end
               end
               default: begin
                  state <= IDLE;
                  count <= '0;
                  irq   <= 1'b0;
               end
            endcase
            if (evt && at_max)
               ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_det_event_counter.sv
// Randomized bench for det_event_counter against an arithmetic reference model.
module tb_det_event_counter;

   localparam int WIDTH  = 4;
   localparam int THRESH = 4;
   localparam int MAX    = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             w   = 1'b0;
   logic             clr = 1'b0;
   logic             ack = 1'b0;
   logic [WIDTH-1:0] count;
   logic             irq;
   logic             ovf;

   int n_tests = 0;
   int n_fail  = 0;

   int m_count = 0;
   bit m_alert = 1'b0;
   bit m_ovf   = 1'b0;
   bit m_wq    = 1'b0;

   det_event_counter #(.WIDTH(WIDTH), .THRESH(THRESH)) dut (
      .clk  (clk),
      .rst  (rst),
      .w    (w),
      .clr  (clr),
      .ack  (ack),
      .count(count),
      .irq  (irq),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_count = 0;
      m_alert = 1'b0;
      m_ovf   = 1'b0;
      m_wq    = 1'b0;
   endfunction

   // One clock edge of the behaviour: detections, threshold, ack, clear.
   function automatic void model_step(input bit wi, input bit ci, input bit ai);
      bit ev;
      ev   = wi && !m_wq;
      m_wq = wi;
      if (ci) begin
         m_count = 0;
         m_alert = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         if (ev && m_count == MAX) m_ovf = 1'b1;
         if (m_alert && ai) begin
            if (ev) begin
               m_count = 1;
               m_alert = (THRESH == 1);
            end else begin
               m_count = 0;
               m_alert = 1'b0;
            end
         end else if (ev) begin
`ifdef DET_SAT_EN
            m_count = (m_count == MAX) ? MAX : m_count + 1;
`else
            m_count = (m_count + 1) % (MAX + 1);
`endif
            if (m_count == THRESH) m_alert = 1'b1;
         end
      end
   endfunction

   task automatic cycle(input bit wi, input bit ci, input bit ai);
      w   = wi;
      clr = ci;
      ack = ai;
      @(posedge clk);
      if (!rst) model_reset();
      else      model_step(wi, ci, ai);
      #1;
      check("count", int'(count), m_count);
      check("irq",   int'(irq),   int'(m_alert));
      check("ovf",   int'(ovf),   int'(m_ovf));
   endtask

   task automatic pulse();
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset entry
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("rst_count", int'(count), 0);
      check("rst_irq",   int'(irq),   0);
      check("rst_ovf",   int'(ovf),   0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      rst = 1'b1;

      // Pulses on cycles 3, 6 and 9
      for (int c = 1; c <= 10; c++) begin
         cycle((c % 3) == 0, 1'b0, 1'b0);
         if (c == 3) check("p3_count", int'(count), 1);
         if (c == 6) check("p6_count", int'(count), 2);
         if (c == 9) check("p9_count", int'(count), 3);
      end
      check("armed_irq", int'(irq), 0);
      check("armed_cnt_nz", int'(count != 0), 1);

      // Held-high w counts once
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      check("hold_count", int'(count), 1);

      // Threshold, extra event, ack
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) pulse();
      check("pre_thr_irq", int'(irq), 0);
      cycle(1'b1, 1'b0, 1'b0);
      check("thr_count", int'(count), 4);
      check("thr_irq",   int'(irq),   1);
      cycle(1'b0, 1'b0, 1'b0);
      pulse();
      check("fifth_count", int'(count), 5);
      check("fifth_irq",   int'(irq),   1);
      cycle(1'b0, 1'b0, 1'b1);
      check("ack_count", int'(count), 0);
      check("ack_irq",   int'(irq),   0);

      // Ack together with an event
      for (int i = 0; i < 4; i++) pulse();
      cycle(1'b1, 1'b0, 1'b1);
      check("ackev_count", int'(count), 1);
      check("ackev_irq",   int'(irq),   0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      check("ack_ignored", int'(count), 1);

      // Sixteen detections reach the counter limit
      cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) pulse();
`ifdef DET_SAT_EN
      check("ovf_count", int'(count), MAX);
`else
      check("ovf_count", int'(count), 0);
`endif
      check("ovf_flag",  int'(ovf), 1);
      check("ovf_irq",   int'(irq), 1);
      cycle(1'b0, 1'b0, 1'b1);
      check("ovf_sticky", int'(ovf), 1);
      cycle(1'b0, 1'b1, 1'b0);
      check("clr_count", int'(count), 0);
      check("clr_ovf",   int'(ovf),   0);

      // Asynchronous reset mid-cycle in ALERT
      for (int i = 0; i < 6; i++) pulse();
      check("pre_rst_count", int'(count), 6);
      check("pre_rst_irq",   int'(irq),   1);
      #3 rst = 1'b0;
      #1;
      model_reset();
      check("async_count", int'(count), 0);
      check("async_irq",   int'(irq),   0);
      check("async_ovf",   int'(ovf),   0);
      cycle(1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cycle(1'b1, 1'b0, 1'b0);
      check("rel_w_high", int'(count), 1);
      cycle(1'b0, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         cycle(1'($urandom_range(0, 1)),
               ($urandom_range(0, 47) == 0),
               (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
